// File: rtl/sync_fifo_if.sv
// Handshake/data bundle between a FIFO and the logic that feeds and drains it.
interface sync_fifo_if #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 8
);
    localparam int ADDR_WIDTH = $clog2(FIFO_DEPTH);

    logic                  wr_inc;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  rd_inc;
    logic                  clr_err;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_valid;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic [ADDR_WIDTH:0]   fill_level;
    logic                  overflow;
    logic                  underflow;

    // Producer/consumer side
    modport master (
        output wr_inc, wr_data, rd_inc, clr_err,
        input  rd_data, rd_valid, full, empty, almost_full, almost_empty,
               fill_level, overflow, underflow
    );

    // FIFO side
    modport slave (
        input  wr_inc, wr_data, rd_inc, clr_err,
        output rd_data, rd_valid, full, empty, almost_full, almost_empty,
               fill_level, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO: power-of-two depth, level-decoded flags, sticky
// overflow/underflow, registered or first-word-fall-through read.
module sync_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 8,
    parameter int ADDR_WIDTH = $clog2(FIFO_DEPTH),
    parameter int AF_THRESH  = FIFO_DEPTH - 2,
    parameter int AE_THRESH  = 2,
    parameter int FWFT       = 0
) (
    input  logic      clk_i,
    input  logic      rst_n_i,
    sync_fifo_if.slave fifo_if
);
    localparam int LVL_W = ADDR_WIDTH + 1;
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE = 1;
    localparam logic [LVL_W-1:0]      LVL_ONE = 1;

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [LVL_W-1:0]      level_q, level_d;
    logic                  ovf_q, ovf_d, udf_q, udf_d;
    logic                  full, empty, wr_acc, rd_acc;

    // Flags come only from the level register, never from the inputs.
    assign full   = (level_q == LVL_W'(FIFO_DEPTH));
    assign empty  = (level_q == '0);
    assign wr_acc = fifo_if.wr_inc & ~full;
    assign rd_acc = fifo_if.rd_inc & ~empty;

    assign fifo_if.full         = full;
    assign fifo_if.empty        = empty;
    assign fifo_if.almost_full  = (level_q >= LVL_W'(AF_THRESH));
    assign fifo_if.almost_empty = (level_q <= LVL_W'(AE_THRESH));
    assign fifo_if.fill_level   = level_q;
    assign fifo_if.overflow     = ovf_q;
    assign fifo_if.underflow    = udf_q;

    // Next-state: pointers wrap naturally, level moves only on a lone op,
    // error flags are sticky and a new event beats the clear.
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        level_d = level_q;
        ovf_d   = ovf_q;
        udf_d   = udf_q;
        if (wr_acc) wptr_d = wptr_q + PTR_ONE;
        if (rd_acc) rptr_d = rptr_q + PTR_ONE;
        case ({wr_acc, rd_acc})
            2'b10:   level_d = level_q + LVL_ONE;
            2'b01:   level_d = level_q - LVL_ONE;
            default: level_d = level_q;
        endcase
        if (fifo_if.clr_err) begin
            ovf_d = 1'b0;
            udf_d = 1'b0;
        end
        if (fifo_if.wr_inc && full)  ovf_d = 1'b1;
        if (fifo_if.rd_inc && empty) udf_d = 1'b1;
    end

    // Control state, cleared asynchronously.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    // Storage array; contents are deliberately left unreset.
    always_ff @(posedge clk_i) begin
        if (wr_acc) mem_q[wptr_q] <= fifo_if.wr_data;
    end

    if (FWFT != 0) begin : g_fwft
        // Head word is always presented; rd_inc just acknowledges it.
        assign fifo_if.rd_data  = mem_q[rptr_q];
        assign fifo_if.rd_valid = ~empty;
    end else begin : g_reg
        logic [DATA_WIDTH-1:0] rd_data_q;
        logic                  rd_valid_q;

        // Registered read: data lands one edge after an accepted pop and holds.
        always_ff @(posedge clk_i or negedge rst_n_i) begin
            if (!rst_n_i) begin
                rd_data_q  <= '0;
                rd_valid_q <= 1'b0;
            end else begin
                rd_valid_q <= rd_acc;
                if (rd_acc) rd_data_q <= mem_q[rptr_q];
            end
        end

        assign fifo_if.rd_data  = rd_data_q;
        assign fifo_if.rd_valid = rd_valid_q;
    end
endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench: registered-read FIFO (u0) driven from a vector table plus
// hand-written corner sequences; fall-through FIFO (u1) via short sequences.
module tb_sync_fifo;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    sync_fifo_if #(.DATA_WIDTH(8), .FIFO_DEPTH(8)) if0 ();
    sync_fifo_if #(.DATA_WIDTH(8), .FIFO_DEPTH(8)) if1 ();

    sync_fifo #(.DATA_WIDTH(8), .FIFO_DEPTH(8), .FWFT(0)) u0 (
        .clk_i(clk), .rst_n_i(rst_n), .fifo_if(if0)
    );
    sync_fifo #(.DATA_WIDTH(8), .FIFO_DEPTH(8), .FWFT(1)) u1 (
        .clk_i(clk), .rst_n_i(rst_n), .fifo_if(if1)
    );

    typedef struct {
        logic [3:0] lvl;
        logic full, empty, af, ae, ovf, udf, rv;
        logic [7:0] rd;
    } obs_t;

    typedef struct {
        logic       wr;
        logic [7:0] wd;
        logic       rd;
        logic       clr;
        obs_t       exp;
    } vec_t;

    function automatic obs_t ob(int lvl, logic f, logic e, logic af, logic ae,
                                logic ovf, logic udf, logic rv, logic [7:0] rd);
        obs_t o;
        o.lvl = 4'(lvl); o.full = f; o.empty = e; o.af = af; o.ae = ae;
        o.ovf = ovf; o.udf = udf; o.rv = rv; o.rd = rd;
        return o;
    endfunction

    function automatic vec_t mk(logic wr, logic [7:0] wd, logic rd, logic clr, obs_t e);
        vec_t v;
        v.wr = wr; v.wd = wd; v.rd = rd; v.clr = clr; v.exp = e;
        return v;
    endfunction

    function automatic obs_t get0();
        return ob(int'(if0.fill_level), if0.full, if0.empty, if0.almost_full,
                  if0.almost_empty, if0.overflow, if0.underflow, if0.rd_valid, if0.rd_data);
    endfunction

    function automatic obs_t get1();
        return ob(int'(if1.fill_level), if1.full, if1.empty, if1.almost_full,
                  if1.almost_empty, if1.overflow, if1.underflow, if1.rd_valid, if1.rd_data);
    endfunction

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cmp(string tag, obs_t a, obs_t e, bit chk_rd);
        chk({tag, ".level"}, int'(a.lvl), int'(e.lvl));
        chk({tag, ".full"},  int'(a.full), int'(e.full));
        chk({tag, ".empty"}, int'(a.empty), int'(e.empty));
        chk({tag, ".af"},    int'(a.af), int'(e.af));
        chk({tag, ".ae"},    int'(a.ae), int'(e.ae));
        chk({tag, ".ovf"},   int'(a.ovf), int'(e.ovf));
        chk({tag, ".udf"},   int'(a.udf), int'(e.udf));
        chk({tag, ".rv"},    int'(a.rv), int'(e.rv));
        if (chk_rd) chk({tag, ".rd_data"}, int'(a.rd), int'(e.rd));
    endtask

    task automatic drv0(logic wr, logic [7:0] wd, logic rd, logic clr);
        if0.wr_inc = wr; if0.wr_data = wd; if0.rd_inc = rd; if0.clr_err = clr;
    endtask

    task automatic drv1(logic wr, logic [7:0] wd, logic rd, logic clr);
        if1.wr_inc = wr; if1.wr_data = wd; if1.rd_inc = rd; if1.clr_err = clr;
    endtask

    // One clock: inputs already driven, sample 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    vec_t tbl[$];

    initial begin
        drv0(0, 8'h00, 0, 0);
        drv1(0, 8'h00, 0, 0);

        // ---- reset state ----
        #2;
        cmp("rst0", get0(), ob(0, 0, 1, 0, 1, 0, 0, 0, 8'h00), 1);
        cmp("rst1", get1(), ob(0, 0, 1, 0, 1, 0, 0, 0, 8'h00), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // ---- table: fill, overflow, clear, drain, underflow, clear ----
        //            wr  wd    rd clr     lvl f e af ae ov ud rv rd
        tbl.push_back(mk(1, 8'h00, 0, 0, ob(1, 0, 0, 0, 1, 0, 0, 0, 8'h00)));
        tbl.push_back(mk(1, 8'h01, 0, 0, ob(2, 0, 0, 0, 1, 0, 0, 0, 8'h00)));
        tbl.push_back(mk(1, 8'h02, 0, 0, ob(3, 0, 0, 0, 0, 0, 0, 0, 8'h00)));
        tbl.push_back(mk(1, 8'h03, 0, 0, ob(4, 0, 0, 0, 0, 0, 0, 0, 8'h00)));
        tbl.push_back(mk(1, 8'h04, 0, 0, ob(5, 0, 0, 0, 0, 0, 0, 0, 8'h00)));
        tbl.push_back(mk(1, 8'h05, 0, 0, ob(6, 0, 0, 1, 0, 0, 0, 0, 8'h00)));
        tbl.push_back(mk(1, 8'h06, 0, 0, ob(7, 0, 0, 1, 0, 0, 0, 0, 8'h00)));
        tbl.push_back(mk(1, 8'h07, 0, 0, ob(8, 1, 0, 1, 0, 0, 0, 0, 8'h00)));
        tbl.push_back(mk(1, 8'hAA, 0, 0, ob(8, 1, 0, 1, 0, 1, 0, 0, 8'h00)));
        tbl.push_back(mk(0, 8'h00, 0, 1, ob(8, 1, 0, 1, 0, 0, 0, 0, 8'h00)));
        tbl.push_back(mk(0, 8'h00, 1, 0, ob(7, 0, 0, 1, 0, 0, 0, 1, 8'h00)));
        tbl.push_back(mk(0, 8'h00, 1, 0, ob(6, 0, 0, 1, 0, 0, 0, 1, 8'h01)));
        tbl.push_back(mk(0, 8'h00, 1, 0, ob(5, 0, 0, 0, 0, 0, 0, 1, 8'h02)));
        tbl.push_back(mk(0, 8'h00, 1, 0, ob(4, 0, 0, 0, 0, 0, 0, 1, 8'h03)));
        tbl.push_back(mk(0, 8'h00, 1, 0, ob(3, 0, 0, 0, 0, 0, 0, 1, 8'h04)));
        tbl.push_back(mk(0, 8'h00, 1, 0, ob(2, 0, 0, 0, 1, 0, 0, 1, 8'h05)));
        tbl.push_back(mk(0, 8'h00, 1, 0, ob(1, 0, 0, 0, 1, 0, 0, 1, 8'h06)));
        tbl.push_back(mk(0, 8'h00, 1, 0, ob(0, 0, 1, 0, 1, 0, 0, 1, 8'h07)));
        tbl.push_back(mk(0, 8'h00, 1, 0, ob(0, 0, 1, 0, 1, 0, 1, 0, 8'h07)));
        tbl.push_back(mk(0, 8'h00, 0, 1, ob(0, 0, 1, 0, 1, 0, 0, 0, 8'h07)));

        foreach (tbl[i]) begin
            drv0(tbl[i].wr, tbl[i].wd, tbl[i].rd, tbl[i].clr);
            tick();
            cmp($sformatf("vec%0d", i), get0(), tbl[i].exp, 1);
        end

        // ---- prime to level 4, then 20 cycles of write+read across wrap ----
        for (int i = 0; i < 4; i++) begin
            drv0(1, 8'(8'h10 + i), 0, 0);
            tick();
            cmp($sformatf("prime%0d", i), get0(),
                ob(i + 1, 0, 0, 0, (i + 1) <= 2, 0, 0, 0, 8'h07), 1);
        end
        for (int i = 0; i < 20; i++) begin
            drv0(1, 8'(8'h14 + i), 1, 0);
            tick();
            cmp($sformatf("stream%0d", i), get0(),
                ob(4, 0, 0, 0, 0, 0, 0, 1, 8'(8'h10 + i)), 1);
        end

        // ---- refill to full, then write+read while full: only read lands ----
        for (int i = 0; i < 4; i++) begin
            drv0(1, 8'(8'h28 + i), 0, 0);
            tick();
            cmp($sformatf("refill%0d", i), get0(),
                ob(5 + i, (5 + i) == 8, 0, (5 + i) >= 6, 0, 0, 0, 0, 8'h23), 1);
        end
        drv0(1, 8'hEE, 1, 0);
        tick();
        cmp("full_wr_rd", get0(), ob(7, 0, 0, 1, 0, 1, 0, 1, 8'h24), 1);
        drv0(0, 8'h00, 0, 0);

        // ---- fall-through mode ----
        drv1(1, 8'h5C, 0, 0);
        tick();
        cmp("fwft_wr", get1(), ob(1, 0, 0, 0, 1, 0, 0, 1, 8'h5C), 1);
        drv1(0, 8'h00, 1, 0);
        tick();
        cmp("fwft_pop", get1(), ob(0, 0, 1, 0, 1, 0, 0, 0, 8'h00), 0);
        drv1(1, 8'h77, 1, 0);
        tick();
        cmp("fwft_wr_rd_empty", get1(), ob(1, 0, 0, 0, 1, 0, 1, 1, 8'h77), 1);
        for (int i = 0; i < 4; i++) begin
            drv1(1, 8'(8'h30 + i), 0, 0);
            tick();
            cmp($sformatf("fwft_fill%0d", i), get1(),
                ob(2 + i, 0, 0, (2 + i) >= 6, (2 + i) <= 2, 0, 1, 1, 8'h77), 1);
        end
        drv1(0, 8'h00, 0, 0);

        // ---- asynchronous reset mid-stream (u1 at level 5, u0 at level 7) ----
        rst_n = 1'b0;
        #1;
        cmp("midrst0", get0(), ob(0, 0, 1, 0, 1, 0, 0, 0, 8'h00), 1);
        cmp("midrst1", get1(), ob(0, 0, 1, 0, 1, 0, 0, 0, 8'h00), 0);
        @(negedge clk);
        rst_n = 1'b1;
        drv0(0, 8'h00, 1, 0);
        drv1(0, 8'h00, 1, 0);
        tick();
        cmp("postrst_rd0", get0(), ob(0, 0, 1, 0, 1, 0, 1, 0, 8'h00), 1);
        cmp("postrst_rd1", get1(), ob(0, 0, 1, 0, 1, 0, 1, 0, 8'h00), 0);
        drv0(0, 8'h00, 0, 0);
        drv1(0, 8'h00, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
